// File: rtl/keypad_pkg.sv
// Shared types and PS/2 set-2 scan codes for the keypad entry controller.
package keypad_pkg;

  // Controller state, encoded so the LED driver can show it directly.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One BCD digit.
  typedef logic [3:0] bcd_t;

  // Numpad digit scan codes, {extended bit, set-2 code}.
  localparam logic [8:0] SC_NUM0 = 9'h070;
  localparam logic [8:0] SC_NUM1 = 9'h069;
  localparam logic [8:0] SC_NUM2 = 9'h072;
  localparam logic [8:0] SC_NUM3 = 9'h07A;
  localparam logic [8:0] SC_NUM4 = 9'h06B;
  localparam logic [8:0] SC_NUM5 = 9'h073;
  localparam logic [8:0] SC_NUM6 = 9'h074;
  localparam logic [8:0] SC_NUM7 = 9'h06C;
  localparam logic [8:0] SC_NUM8 = 9'h075;
  localparam logic [8:0] SC_NUM9 = 9'h07D;

  // Editing and command keys; numpad ENTER carries the extended prefix.
  localparam logic [8:0] SC_BKSP  = 9'h066;
  localparam logic [8:0] SC_ESC   = 9'h076;
  localparam logic [8:0] SC_ENTER = 9'h15A;

endpackage

// File: rtl/keycode_to_digit.sv
// Combinational scan-code classifier: maps a key code to a digit or command.
module keycode_to_digit
  import keypad_pkg::*;
#(
  parameter int MAX_DIGIT = 9
) (
  input  logic [8:0] keyCode_i,
  output logic       isDigit_o,
  output bcd_t       digit_o,
  output logic       isBksp_o,
  output logic       isEsc_o,
  output logic       isEnter_o
);

  logic rawHit;
  bcd_t rawDigit;

  // Look up the code; digits above MAX_DIGIT are treated as unknown keys.
  always_comb begin
    rawHit    = 1'b1;
    rawDigit  = 4'd0;
    isBksp_o  = 1'b0;
    isEsc_o   = 1'b0;
    isEnter_o = 1'b0;
    case (keyCode_i)
      SC_NUM0:  rawDigit = 4'd0;
      SC_NUM1:  rawDigit = 4'd1;
      SC_NUM2:  rawDigit = 4'd2;
      SC_NUM3:  rawDigit = 4'd3;
      SC_NUM4:  rawDigit = 4'd4;
      SC_NUM5:  rawDigit = 4'd5;
      SC_NUM6:  rawDigit = 4'd6;
      SC_NUM7:  rawDigit = 4'd7;
      SC_NUM8:  rawDigit = 4'd8;
      SC_NUM9:  rawDigit = 4'd9;
      SC_BKSP:  begin rawHit = 1'b0; isBksp_o  = 1'b1; end
      SC_ESC:   begin rawHit = 1'b0; isEsc_o   = 1'b1; end
      SC_ENTER: begin rawHit = 1'b0; isEnter_o = 1'b1; end
      default:  rawHit = 1'b0;
    endcase
    isDigit_o = rawHit && (int'(rawDigit) <= MAX_DIGIT);
    digit_o   = rawDigit;
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Numeric entry controller: collects keypad digits into a right-aligned BCD
// buffer with backspace/clear, and latches the value on commit.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_DIGIT  = 9,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic                    key_make,
  input  logic [8:0]              key_code,
  input  logic                    control_btn,
  input  logic                    finish_btn,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [CNT_W-1:0]        digit_count,
  output logic [4*NUM_DIGITS-1:0] committed_bcd,
  output logic                    commit_pulse,
  output logic                    overflow,
  output logic [1:0]              state
);

  localparam int BUF_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(NUM_DIGITS);

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   digits_q, digits_d;
  logic [BUF_W-1:0]   committed_q, committed_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               commitPulse_q, commitPulse_d;
  logic               overflow_q, overflow_d;
  logic               ctrlBtn_q, finBtn_q;

  logic ctrlEdge, finEdge, keyEvent;
  logic isDigit, isBksp, isEsc, isEnter;
  bcd_t keyDigit;

  keycode_to_digit #(
    .MAX_DIGIT (MAX_DIGIT)
  ) u_decode (
    .keyCode_i (key_code),
    .isDigit_o (isDigit),
    .digit_o   (keyDigit),
    .isBksp_o  (isBksp),
    .isEsc_o   (isEsc),
    .isEnter_o (isEnter)
  );

  assign ctrlEdge = control_btn & ~ctrlBtn_q;
  assign finEdge  = finish_btn & ~finBtn_q;
  assign keyEvent = key_valid & key_make;

  // Push a new digit into position 0, moving the others up one place.
  function automatic logic [BUF_W-1:0] shiftIn(input logic [BUF_W-1:0] cur,
                                               input bcd_t d);
    logic [BUF_W-1:0] r;
    r      = '0;
    r[3:0] = d;
    for (int i = 1; i < NUM_DIGITS; i++) r[4*i +: 4] = cur[4*(i-1) +: 4];
    return r;
  endfunction

  // Drop digit 0, moving the others down and zero-filling the top digit.
  function automatic logic [BUF_W-1:0] shiftOut(input logic [BUF_W-1:0] cur);
    logic [BUF_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS - 1; i++) r[4*i +: 4] = cur[4*(i+1) +: 4];
    return r;
  endfunction

  // Next-state logic; priority is control edge, then finish edge, then key.
  always_comb begin
    state_d       = state_q;
    digits_d      = digits_q;
    committed_d   = committed_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    commitPulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrlEdge) begin
          state_d    = ENTRY;
          digits_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      ENTRY: begin
        if (ctrlEdge) begin
          state_d  = IDLE;
          digits_d = '0;
          count_d  = '0;
        end else if (finEdge || (keyEvent && isEnter)) begin
          state_d       = DONE;
          committed_d   = digits_q;
          commitPulse_d = 1'b1;
        end else if (keyEvent) begin
          if (isDigit) begin
            if (count_q < COUNT_FULL) begin
              digits_d = shiftIn(digits_q, keyDigit);
              count_d  = count_q + CNT_W'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end else if (isBksp) begin
            if (count_q != '0) begin
              digits_d = shiftOut(digits_q);
              count_d  = count_q - CNT_W'(1);
            end
          end else if (isEsc) begin
            digits_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (ctrlEdge) begin
          state_d    = ENTRY;
          digits_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and button-history registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      digits_q      <= '0;
      committed_q   <= '0;
      count_q       <= '0;
      commitPulse_q <= 1'b0;
      overflow_q    <= 1'b0;
      ctrlBtn_q     <= 1'b0;
      finBtn_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      digits_q      <= digits_d;
      committed_q   <= committed_d;
      count_q       <= count_d;
      commitPulse_q <= commitPulse_d;
      overflow_q    <= overflow_d;
      ctrlBtn_q     <= control_btn;
      finBtn_q      <= finish_btn;
    end
  end

  // Blank every display position at or above the registered digit count.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) blank_mask[i] = (i >= int'(count_q));
  end

  assign digits_bcd    = digits_q;
  assign digit_count   = count_q;
  assign committed_bcd = committed_q;
  assign commit_pulse  = commitPulse_q;
  assign overflow      = overflow_q;
  assign state         = state_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Testbench for keypad_entry_ctrl: a default build (digits 0-9) driven from
// a vector table, plus a legacy build (digits 0-3) sharing the same inputs.
module tb_keypad_entry_ctrl;

  typedef struct {
    logic        kv;
    logic        km;
    logic [8:0]  kc;
    logic        ctrl;
    logic        fin;
    logic [15:0] eDig;
    logic [2:0]  eCnt;
    logic [3:0]  eBlank;
    logic        eOv;
    logic [1:0]  eState;
    logic        ePulse;
    logic [15:0] eComm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        keyValid, keyMake, controlBtn, finishBtn;
  logic [8:0]  keyCode;

  logic [15:0] digitsBcd, committedBcd, digitsBcd3, committedBcd3;
  logic [3:0]  blankMask, blankMask3;
  logic [2:0]  digitCount, digitCount3;
  logic        commitPulse, overflow, commitPulse3, overflow3;
  logic [1:0]  state, state3;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  keypad_entry_ctrl #(.NUM_DIGITS(4), .MAX_DIGIT(9)) dut (
    .clk(clk), .rst(rst), .key_valid(keyValid), .key_make(keyMake),
    .key_code(keyCode), .control_btn(controlBtn), .finish_btn(finishBtn),
    .digits_bcd(digitsBcd), .blank_mask(blankMask), .digit_count(digitCount),
    .committed_bcd(committedBcd), .commit_pulse(commitPulse),
    .overflow(overflow), .state(state)
  );

  keypad_entry_ctrl #(.NUM_DIGITS(4), .MAX_DIGIT(3)) dutLegacy (
    .clk(clk), .rst(rst), .key_valid(keyValid), .key_make(keyMake),
    .key_code(keyCode), .control_btn(controlBtn), .finish_btn(finishBtn),
    .digits_bcd(digitsBcd3), .blank_mask(blankMask3), .digit_count(digitCount3),
    .committed_bcd(committedBcd3), .commit_pulse(commitPulse3),
    .overflow(overflow3), .state(state3)
  );

  function automatic vec_t mkVec(logic kv, logic km, logic [8:0] kc,
                                 logic ctrl, logic fin, logic [15:0] eDig,
                                 logic [2:0] eCnt, logic [3:0] eBlank,
                                 logic eOv, logic [1:0] eState,
                                 logic ePulse, logic [15:0] eComm);
    vec_t v;
    v.kv = kv; v.km = km; v.kc = kc; v.ctrl = ctrl; v.fin = fin;
    v.eDig = eDig; v.eCnt = eCnt; v.eBlank = eBlank; v.eOv = eOv;
    v.eState = eState; v.ePulse = ePulse; v.eComm = eComm;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample 1ns past the rising edge.
  task automatic applyStimulus(input logic r, input logic kv, input logic km,
                               input logic [8:0] kc, input logic ctrl,
                               input logic fin);
    @(negedge clk);
    rst = r; keyValid = kv; keyMake = km; keyCode = kc;
    controlBtn = ctrl; finishBtn = fin;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag,
                             input logic [15:0] aDig, input logic [2:0] aCnt,
                             input logic [3:0] aBlank, input logic aOv,
                             input logic [1:0] aState, input logic aPulse,
                             input logic [15:0] aComm,
                             input logic [15:0] eDig, input logic [2:0] eCnt,
                             input logic [3:0] eBlank, input logic eOv,
                             input logic [1:0] eState, input logic ePulse,
                             input logic [15:0] eComm);
    cmp({tag, ".digits"}, aDig, eDig);
    cmp({tag, ".count"}, 16'(aCnt), 16'(eCnt));
    cmp({tag, ".blank"}, 16'(aBlank), 16'(eBlank));
    cmp({tag, ".overflow"}, 16'(aOv), 16'(eOv));
    cmp({tag, ".state"}, 16'(aState), 16'(eState));
    cmp({tag, ".pulse"}, 16'(aPulse), 16'(ePulse));
    cmp({tag, ".committed"}, aComm, eComm);
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Vector table for the default build: inputs then expected outputs.
    vecs.push_back(mkVec(0,0,9'h000,1,0, 16'h0000,0,4'hF,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h069,0,0, 16'h0001,1,4'hE,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h072,0,0, 16'h0012,2,4'hC,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h07A,0,0, 16'h0123,3,4'h8,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h06B,0,0, 16'h1234,4,4'h0,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h073,0,0, 16'h1234,4,4'h0,1,1,0,16'h0000));
    vecs.push_back(mkVec(1,0,9'h06B,0,0, 16'h1234,4,4'h0,1,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h076,0,0, 16'h0000,0,4'hF,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h069,0,0, 16'h0001,1,4'hE,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h072,0,0, 16'h0012,2,4'hC,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h066,0,0, 16'h0001,1,4'hE,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h066,0,0, 16'h0000,0,4'hF,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h066,0,0, 16'h0000,0,4'hF,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h06B,0,0, 16'h0004,1,4'hE,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h072,0,0, 16'h0042,2,4'hC,0,1,0,16'h0000));
    vecs.push_back(mkVec(0,0,9'h000,0,1, 16'h0042,2,4'hC,0,2,1,16'h0042));
    vecs.push_back(mkVec(1,1,9'h069,0,1, 16'h0042,2,4'hC,0,2,0,16'h0042));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mkVec(0,0,9'h000,0,1, 16'h0042,2,4'hC,0,2,0,16'h0042));
    vecs.push_back(mkVec(1,1,9'h15A,0,0, 16'h0042,2,4'hC,0,2,0,16'h0042));
    vecs.push_back(mkVec(0,0,9'h000,1,0, 16'h0000,0,4'hF,0,1,0,16'h0042));
    vecs.push_back(mkVec(1,1,9'h07D,0,0, 16'h0009,1,4'hE,0,1,0,16'h0042));
    vecs.push_back(mkVec(1,1,9'h069,0,1, 16'h0009,1,4'hE,0,2,1,16'h0009));
    vecs.push_back(mkVec(0,0,9'h000,1,0, 16'h0000,0,4'hF,0,1,0,16'h0009));
    vecs.push_back(mkVec(1,1,9'h075,0,0, 16'h0008,1,4'hE,0,1,0,16'h0009));
    vecs.push_back(mkVec(0,0,9'h000,1,1, 16'h0000,0,4'hF,0,0,0,16'h0009));
    vecs.push_back(mkVec(1,1,9'h069,0,0, 16'h0000,0,4'hF,0,0,0,16'h0009));
    vecs.push_back(mkVec(0,0,9'h000,0,1, 16'h0000,0,4'hF,0,0,0,16'h0009));
    vecs.push_back(mkVec(0,0,9'h000,1,0, 16'h0000,0,4'hF,0,1,0,16'h0009));
    vecs.push_back(mkVec(1,1,9'h15A,0,0, 16'h0000,0,4'hF,0,2,1,16'h0000));
    vecs.push_back(mkVec(0,0,9'h000,0,0, 16'h0000,0,4'hF,0,2,0,16'h0000));
    vecs.push_back(mkVec(0,0,9'h000,1,0, 16'h0000,0,4'hF,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h074,1,0, 16'h0006,1,4'hE,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h01C,0,0, 16'h0006,1,4'hE,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h170,0,0, 16'h0006,1,4'hE,0,1,0,16'h0000));
    vecs.push_back(mkVec(1,1,9'h06C,0,0, 16'h0067,2,4'hC,0,1,0,16'h0000));
    vecs.push_back(mkVec(0,0,9'h000,0,1, 16'h0067,2,4'hC,0,2,1,16'h0067));

    rst = 1'b1; keyValid = 1'b0; keyMake = 1'b0; keyCode = 9'h000;
    controlBtn = 1'b0; finishBtn = 1'b0;
    repeat (2) applyStimulus(1, 0, 0, 9'h000, 0, 0);
    checkOutput("reset", digitsBcd, digitCount, blankMask, overflow, state,
                commitPulse, committedBcd, 16'h0000, 0, 4'hF, 0, 0, 0, 16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].kv, vecs[i].km, vecs[i].kc, vecs[i].ctrl, vecs[i].fin);
      checkOutput($sformatf("vec%0d", i), digitsBcd, digitCount, blankMask,
                  overflow, state, commitPulse, committedBcd,
                  vecs[i].eDig, vecs[i].eCnt, vecs[i].eBlank, vecs[i].eOv,
                  vecs[i].eState, vecs[i].ePulse, vecs[i].eComm);
    end

    // Reset wins over a simultaneous control edge and key from DONE.
    applyStimulus(1, 1, 1, 9'h069, 1, 0);
    checkOutput("rstDone", digitsBcd, digitCount, blankMask, overflow, state,
                commitPulse, committedBcd, 16'h0000, 0, 4'hF, 0, 0, 0, 16'h0000);
    checkOutput("rstLegacy", digitsBcd3, digitCount3, blankMask3, overflow3, state3,
                commitPulse3, committedBcd3, 16'h0000, 0, 4'hF, 0, 0, 0, 16'h0000);

    // Button history was cleared by reset, so a held button now reads as an edge.
    applyStimulus(0, 0, 0, 9'h000, 1, 0);
    checkOutput("heldCtrl", digitsBcd, digitCount, blankMask, overflow, state,
                commitPulse, committedBcd, 16'h0000, 0, 4'hF, 0, 1, 0, 16'h0000);
    checkOutput("heldCtrlL", digitsBcd3, digitCount3, blankMask3, overflow3, state3,
                commitPulse3, committedBcd3, 16'h0000, 0, 4'hF, 0, 1, 0, 16'h0000);

    // Legacy build drops numpad 4 but takes 3; default build takes both.
    applyStimulus(0, 1, 1, 9'h06B, 0, 0);
    checkOutput("key4", digitsBcd, digitCount, blankMask, overflow, state,
                commitPulse, committedBcd, 16'h0004, 1, 4'hE, 0, 1, 0, 16'h0000);
    checkOutput("key4L", digitsBcd3, digitCount3, blankMask3, overflow3, state3,
                commitPulse3, committedBcd3, 16'h0000, 0, 4'hF, 0, 1, 0, 16'h0000);
    applyStimulus(0, 1, 1, 9'h07A, 0, 0);
    checkOutput("key3", digitsBcd, digitCount, blankMask, overflow, state,
                commitPulse, committedBcd, 16'h0043, 2, 4'hC, 0, 1, 0, 16'h0000);
    checkOutput("key3L", digitsBcd3, digitCount3, blankMask3, overflow3, state3,
                commitPulse3, committedBcd3, 16'h0003, 1, 4'hE, 0, 1, 0, 16'h0000);
    applyStimulus(0, 1, 1, 9'h069, 0, 0);
    checkOutput("key1", digitsBcd, digitCount, blankMask, overflow, state,
                commitPulse, committedBcd, 16'h0431, 3, 4'h8, 0, 1, 0, 16'h0000);
    checkOutput("key1L", digitsBcd3, digitCount3, blankMask3, overflow3, state3,
                commitPulse3, committedBcd3, 16'h0031, 2, 4'hC, 0, 1, 0, 16'h0000);

    // Reset in the middle of an entry.
    applyStimulus(1, 0, 0, 9'h000, 0, 0);
    checkOutput("rstEntry", digitsBcd, digitCount, blankMask, overflow, state,
                commitPulse, committedBcd, 16'h0000, 0, 4'hF, 0, 0, 0, 16'h0000);
    checkOutput("rstEntryL", digitsBcd3, digitCount3, blankMask3, overflow3, state3,
                commitPulse3, committedBcd3, 16'h0000, 0, 4'hF, 0, 0, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
